// File: rtl/segasys1_video_timing.sv
// Raster timing generator for the System 1 video pipeline: PH/PV beam counters,
// blanking, user-adjustable sync, frame count and the VBLANK interrupt request.
module segasys1_video_timing #(
  parameter int H_TOTAL  = 384,
  parameter int H_ACTIVE = 256,
  parameter int HS_START = 304,
  parameter int HS_WIDTH = 32,
  parameter int V_TOTAL  = 264,
  parameter int V_ACTIVE = 224,
  parameter int VS_START = 236,
  parameter int VS_WIDTH = 3
) (
  input  logic       VCLKx8,
  input  logic       RESET,
  input  logic       PCLK_EN,
  input  logic [3:0] HOFS,
  input  logic [2:0] VOFS,
  input  logic       IRQ_ACK,
  output logic [8:0] PH,
  output logic [8:0] PV,
  output logic       HBLK,
  output logic       VBLK,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       IRQ,
  output logic [7:0] FRAME
);

  localparam logic [8:0] H_LAST  = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST  = 9'(V_TOTAL - 1);
  localparam logic [8:0] H_ACT   = 9'(H_ACTIVE);
  localparam logic [8:0] V_ACT   = 9'(V_ACTIVE);
  localparam logic [8:0] HS_BASE = 9'(HS_START);
  localparam logic [8:0] HS_LEN  = 9'(HS_WIDTH);
  localparam logic [8:0] VS_BASE = 9'(VS_START);
  localparam logic [8:0] VS_LEN  = 9'(VS_WIDTH);

  logic [8:0] hofs_l;
  logic [8:0] vofs_l;

  logic       h_wrap;
  logic       f_wrap;
  logic [8:0] ph_nxt;
  logic [8:0] pv_nxt;
  logic [7:0] frame_nxt;
  logic [8:0] hofs_nxt;
  logic [8:0] vofs_nxt;
  logic [8:0] hs_lo;
  logic [8:0] hs_hi;
  logic [8:0] vs_lo;
  logic [8:0] vs_hi;
  logic       hblk_nxt;
  logic       vblk_nxt;
  logic       hsync_nxt;
  logic       vsync_nxt;
  logic       irq_set;

  // NOTE: every signal driven in this block is given a default first, so no
  // branch can leave one unassigned and infer a latch.
  always_comb begin
    ph_nxt    = PH + 9'd1;
    pv_nxt    = PV;
    frame_nxt = FRAME;
    hofs_nxt  = hofs_l;
    vofs_nxt  = vofs_l;
    h_wrap    = (PH == H_LAST);
    f_wrap    = h_wrap && (PV == V_LAST);

    if (h_wrap) begin
      ph_nxt = 9'd0;
      pv_nxt = f_wrap ? 9'd0 : PV + 9'd1;
    end

    // Offsets are sampled only at the frame boundary; decoding the new frame's
    // first pixel already uses the freshly captured values.
    if (f_wrap) begin
      frame_nxt = FRAME + 8'd1;
      hofs_nxt  = {{5{HOFS[3]}}, HOFS};
      vofs_nxt  = {{6{VOFS[2]}}, VOFS};
    end

    hs_lo = HS_BASE + hofs_nxt;
    hs_hi = hs_lo + HS_LEN;
    vs_lo = VS_BASE + vofs_nxt;
    vs_hi = vs_lo + VS_LEN;

    hblk_nxt  = (ph_nxt >= H_ACT);
    vblk_nxt  = (pv_nxt >= V_ACT);
    hsync_nxt = (ph_nxt >= hs_lo) && (ph_nxt < hs_hi);
    vsync_nxt = (pv_nxt >= vs_lo) && (pv_nxt < vs_hi);

    irq_set = PCLK_EN && h_wrap && (pv_nxt == V_ACT);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge VCLKx8) begin
    if (RESET) begin
      PH     <= 9'd0;
      PV     <= 9'd0;
      FRAME  <= 8'd0;
      HBLK   <= 1'b0;
      VBLK   <= 1'b0;
      HSYNC  <= 1'b0;
      VSYNC  <= 1'b0;
      IRQ    <= 1'b0;
      hofs_l <= 9'd0;
      vofs_l <= 9'd0;
    end else begin
      if (PCLK_EN) begin
        PH     <= ph_nxt;
        PV     <= pv_nxt;
        FRAME  <= frame_nxt;
        HBLK   <= hblk_nxt;
        VBLK   <= vblk_nxt;
        HSYNC  <= hsync_nxt;
        VSYNC  <= vsync_nxt;
        hofs_l <= hofs_nxt;
        vofs_l <= vofs_nxt;
      end
      // Set has priority over a coincident acknowledge.
      if (irq_set) begin
        IRQ <= 1'b1;
      end else if (IRQ_ACK) begin
        IRQ <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_segasys1_video_timing.sv
// Bench for segasys1_video_timing: a full-size instance for the horizontal behaviour and a
// shrunken instance so whole frames, offsets, IRQ and FRAME wrap fit in a short run.
module tb_segasys1_video_timing;

  typedef struct packed {
    int ht; int ha; int hs; int hw;
    int vt; int va; int vs; int vw;
  } cfg_t;

  localparam cfg_t CFG_A = '{ht: 384, ha: 256, hs: 304, hw: 32, vt: 264, va: 224, vs: 236, vw: 3};
  localparam cfg_t CFG_B = '{ht: 20,  ha: 12,  hs: 10,  hw: 3,  vt: 8,   va: 5,   vs: 4,   vw: 1};

  logic       clk;
  logic       rst   [2];
  logic       pen   [2];
  logic       ack   [2];
  logic [3:0] hofs  [2];
  logic [2:0] vofs  [2];
  logic [8:0] ph    [2];
  logic [8:0] pv    [2];
  logic       hblk  [2];
  logic       vblk  [2];
  logic       hsync [2];
  logic       vsync [2];
  logic       irq   [2];
  logic [7:0] frame [2];

  int checks   = 0;
  int failures = 0;

  segasys1_video_timing dut_a (
    .VCLKx8(clk), .RESET(rst[0]), .PCLK_EN(pen[0]), .HOFS(hofs[0]), .VOFS(vofs[0]),
    .IRQ_ACK(ack[0]), .PH(ph[0]), .PV(pv[0]), .HBLK(hblk[0]), .VBLK(vblk[0]),
    .HSYNC(hsync[0]), .VSYNC(vsync[0]), .IRQ(irq[0]), .FRAME(frame[0])
  );

  segasys1_video_timing #(
    .H_TOTAL(20), .H_ACTIVE(12), .HS_START(10), .HS_WIDTH(3),
    .V_TOTAL(8),  .V_ACTIVE(5),  .VS_START(4),  .VS_WIDTH(1)
  ) dut_b (
    .VCLKx8(clk), .RESET(rst[1]), .PCLK_EN(pen[1]), .HOFS(hofs[1]), .VOFS(vofs[1]),
    .IRQ_ACK(ack[1]), .PH(ph[1]), .PV(pv[1]), .HBLK(hblk[1]), .VBLK(vblk[1]),
    .HSYNC(hsync[1]), .VSYNC(vsync[1]), .IRQ(irq[1]), .FRAME(frame[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference model: the raster is just a pixel index since reset; position,
  // blanking, sync and frame number all follow from it by division.
  int m_t   [2];
  int m_ho  [2];
  int m_vo  [2];
  bit m_irq [2];
  bit m_ok  [2];

  function automatic cfg_t cfg_of(input int i);
    return (i == 0) ? CFG_A : CFG_B;
  endfunction

  function automatic logic [30:0] model_out(input int i);
    cfg_t c;
    int flen, pix, x, y, f;
    logic hs, vs;
    c    = cfg_of(i);
    flen = c.ht * c.vt;
    pix  = m_t[i] % flen;
    x    = pix % c.ht;
    y    = pix / c.ht;
    f    = m_t[i] / flen;
    hs   = (x >= c.hs + m_ho[i]) && (x < c.hs + m_ho[i] + c.hw);
    vs   = (y >= c.vs + m_vo[i]) && (y < c.vs + m_vo[i] + c.vw);
    return {9'(x), 9'(y), (x >= c.ha), (y >= c.va), hs, vs, m_irq[i], 8'(f)};
  endfunction

  function automatic logic [30:0] dut_out(input int i);
    return {ph[i], pv[i], hblk[i], vblk[i], hsync[i], vsync[i], irq[i], frame[i]};
  endfunction

  always @(posedge clk) begin
    cfg_t c;
    int flen, pix;
    bit set;
    for (int i = 0; i < 2; i++) begin
      c    = cfg_of(i);
      flen = c.ht * c.vt;
      if (rst[i] === 1'b1) begin
        m_t[i]   = 0;
        m_ho[i]  = 0;
        m_vo[i]  = 0;
        m_irq[i] = 1'b0;
        m_ok[i]  = 1'b1;
      end else if (m_ok[i]) begin
        set = 1'b0;
        if (pen[i]) begin
          m_t[i] = (m_t[i] + 1) % (flen * 256);
          pix    = m_t[i] % flen;
          if (pix == 0) begin
            m_ho[i] = int'($signed(hofs[i]));
            m_vo[i] = int'($signed(vofs[i]));
          end
          set = (pix == c.va * c.ht);
        end
        if (set) m_irq[i] = 1'b1;
        else if (ack[i]) m_irq[i] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok[0]) check("dut_a_outputs", 32'(dut_out(0)), 32'(model_out(0)));
    if (m_ok[1]) check("dut_b_outputs", 32'(dut_out(1)), 32'(model_out(1)));
  end

  task automatic tick(input logic pa, input logic pb);
    pen[0] = pa;
    pen[1] = pb;
    @(negedge clk);
  endtask

  task automatic run_to(input int i, input int target);
    int n;
    n = target - m_t[i];
    if (n < 0) begin
      failures++;
      $display("FAIL run_to: target %0d behind position %0d", target, m_t[i]);
    end
    repeat (n) tick(i == 0, i == 1);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i]  = 1'b1;
      pen[i]  = 1'b0;
      ack[i]  = 1'b0;
      hofs[i] = 4'd0;
      vofs[i] = 3'd0;
    end
    repeat (3) tick(1'b0, 1'b0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Reset state, both instances.
    check("a_reset_ph", 32'(ph[0]), 0);
    check("a_reset_pv", 32'(pv[0]), 0);
    check("a_reset_flags", 32'({hblk[0], vblk[0], hsync[0], vsync[0], irq[0]}), 0);
    check("a_reset_frame", 32'(frame[0]), 0);
    check("b_reset_all", 32'(dut_out(1)), 0);

    // Full-size instance at 1-in-8 pixel rate: edge of the active region.
    for (int k = 0; k < 255; k++) begin
      repeat (7) tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
    end
    check("a_ph_255", 32'(ph[0]), 255);
    check("a_hblk_255", 32'(hblk[0]), 0);
    repeat (7) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    check("a_ph_256", 32'(ph[0]), 256);
    check("a_hblk_256", 32'(hblk[0]), 1);

    // Line wrap and nominal HSYNC window.
    run_to(0, 10 * 384 + 383);
    check("a_ph_383", 32'(ph[0]), 383);
    check("a_pv_10", 32'(pv[0]), 10);
    tick(1'b1, 1'b0);
    check("a_wrap_ph", 32'(ph[0]), 0);
    check("a_wrap_pv", 32'(pv[0]), 11);
    run_to(0, 11 * 384 + 303);
    check("a_hsync_303", 32'(hsync[0]), 0);
    tick(1'b1, 1'b0);
    check("a_hsync_304", 32'(hsync[0]), 1);
    run_to(0, 11 * 384 + 335);
    check("a_hsync_335", 32'(hsync[0]), 1);
    tick(1'b1, 1'b0);
    check("a_hsync_336", 32'(hsync[0]), 0);
    pen[0] = 1'b0;

    // Small instance: 20x8 raster, VBLANK at line 5.
    run_to(1, 4 * 20 + 19);
    check("b_irq_pre", 32'(irq[1]), 0);
    check("b_vblk_pre", 32'(vblk[1]), 0);
    tick(1'b0, 1'b1);
    check("b_irq_set", 32'(irq[1]), 1);
    check("b_vblk_set", 32'(vblk[1]), 1);
    check("b_pv_224eq", 32'(pv[1]), 5);
    run_to(1, 6 * 20);
    ack[1] = 1'b1;
    tick(1'b0, 1'b0);
    ack[1] = 1'b0;
    check("b_irq_acked", 32'(irq[1]), 0);
    run_to(1, 160 + 100);
    check("b_irq_frame1", 32'(irq[1]), 1);
    run_to(1, 3 * 160);
    check("b_irq_held_2frames", 32'(irq[1]), 1);

    // Set and acknowledge on the same edge: set wins.
    run_to(1, 3 * 160 + 99);
    ack[1] = 1'b1;
    tick(1'b0, 1'b1);
    check("b_irq_set_wins", 32'(irq[1]), 1);
    ack[1] = 1'b0;
    tick(1'b0, 1'b0);
    check("b_irq_after_release", 32'(irq[1]), 1);
    ack[1] = 1'b1;
    tick(1'b0, 1'b0);
    ack[1] = 1'b0;
    check("b_irq_cleared", 32'(irq[1]), 0);

    // Offsets applied mid-frame take effect from the next frame only.
    run_to(1, 4 * 160 + 2 * 20);
    hofs[1] = 4'b1100;
    vofs[1] = 3'd3;
    run_to(1, 4 * 160 + 3 * 20 + 9);
    check("b_hs_cur_9", 32'(hsync[1]), 0);
    tick(1'b0, 1'b1);
    check("b_hs_cur_10", 32'(hsync[1]), 1);
    run_to(1, 4 * 160 + 3 * 20 + 12);
    check("b_hs_cur_12", 32'(hsync[1]), 1);
    tick(1'b0, 1'b1);
    check("b_hs_cur_13", 32'(hsync[1]), 0);
    run_to(1, 4 * 160 + 4 * 20);
    check("b_vs_cur_4", 32'(vsync[1]), 1);
    run_to(1, 5 * 160 + 20 + 5);
    check("b_hs_nxt_5", 32'(hsync[1]), 0);
    tick(1'b0, 1'b1);
    check("b_hs_nxt_6", 32'(hsync[1]), 1);
    run_to(1, 5 * 160 + 20 + 8);
    check("b_hs_nxt_8", 32'(hsync[1]), 1);
    tick(1'b0, 1'b1);
    check("b_hs_nxt_9", 32'(hsync[1]), 0);
    run_to(1, 5 * 160 + 4 * 20);
    check("b_vs_nxt_4", 32'(vsync[1]), 0);
    run_to(1, 5 * 160 + 6 * 20 + 19);
    check("b_vs_nxt_6", 32'(vsync[1]), 0);
    tick(1'b0, 1'b1);
    check("b_vs_nxt_7", 32'(vsync[1]), 1);

    // Frame counter wrap 255 -> 0.
    run_to(1, 255 * 160 + 159);
    check("b_frame_255", 32'(frame[1]), 255);
    check("b_pv_last", 32'(pv[1]), 7);
    check("b_ph_last", 32'(ph[1]), 19);
    tick(1'b0, 1'b1);
    check("b_frame_wrap", 32'(frame[1]), 0);
    check("b_pos_wrap", 32'({ph[1], pv[1]}), 0);

    // Reset mid-frame with IRQ pending and offsets latched, then a frozen pixel clock.
    run_to(1, 3 * 20 + 7);
    check("b_irq_before_reset", 32'(irq[1]), 1);
    rst[1] = 1'b1;
    tick(1'b0, 1'b1);
    rst[1] = 1'b0;
    check("b_rst_all", 32'(dut_out(1)), 0);
    repeat (40) tick(1'b0, 1'b0);
    check("b_frozen", 32'(dut_out(1)), 0);
    run_to(1, 9);
    check("b_rst_hs_9", 32'(hsync[1]), 0);
    tick(1'b0, 1'b1);
    check("b_rst_hs_10", 32'(hsync[1]), 1);
    run_to(1, 4 * 20);
    check("b_rst_vs_4", 32'(vsync[1]), 1);
    pen[1] = 1'b0;
    tick(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
